// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fetch_pkg                                               |
// | Brief    : shared constants, state enum and entry type for fetch   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package fetch_pkg;

  localparam logic [31:0] C_NOP      = 32'h0000_0013;
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fetch_fifo                                              |
// | Brief    : synchronous FIFO of {instr, pc} entries with clear      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is only legal when a pop frees a slot the same cycle
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fetch_unit                                              |
// | Brief    : RV32I fetch front end: PC, imem request/response, decode|
// |            handshake. Define FETCH_BYPASS_EN for 0-cycle bypass.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_last_pc;
  logic [31:0]   w_redirect_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] w_discard_nxt;
  logic [CW-1:0] w_count;
  logic          w_credit_ok;
  logic          w_grant;
  logic          w_resp;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_unused_full;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  assign w_redirect_pc = word_align(redirect_pc);

  // Outstanding requests and buffered words share one DEPTH-sized credit pool
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_count}) < (CW+1)'(DEPTH);
  assign imem_req    = (r_state == ST_FETCH) && !redirect && w_credit_ok;
  assign imem_addr   = r_pc;
  assign w_grant     = imem_req && imem_gnt;
  assign w_resp      = imem_rvalid && (r_outstanding != '0);
  assign w_accept    = w_resp && (r_state == ST_FETCH) && !redirect;

  // Grant is never seen during redirect, so this is also the discard reload value
  assign w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(w_resp);

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    case (r_state)
      ST_RESET: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (redirect && (w_outstanding_nxt != '0)) begin
          w_state_nxt   = ST_FLUSH;
          w_discard_nxt = w_outstanding_nxt;
        end
      end
      ST_FLUSH: begin
        if (redirect)    w_discard_nxt = w_outstanding_nxt;
        else if (w_resp) w_discard_nxt = r_discard - CW'(1);
        if (w_discard_nxt == '0) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RESET;
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_last_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      if (redirect) begin
        r_pc      <= w_redirect_pc;
        r_resp_pc <= w_redirect_pc;
      end else begin
        if (w_grant)  r_pc      <= r_pc + 32'd4;
        if (w_accept) r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (instr_valid) r_last_pc <= instr_pc;
    end
  end

  assign w_push_entry = {imem_rdata, r_resp_pc};
  assign w_pop        = !w_empty && dec_ready && !redirect;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;

  // Response goes straight to decode when nothing older is waiting
  assign w_bypass    = w_empty && w_accept;
  assign w_push      = w_accept && !(w_bypass && dec_ready);
  assign instr_valid = !w_empty || w_bypass;

  always_comb begin
    instr_out = C_NOP;
    instr_pc  = r_last_pc;
    if (!w_empty) begin
      instr_out = w_head.instr;
      instr_pc  = w_head.pc;
    end else if (w_bypass) begin
      instr_out = imem_rdata;
      instr_pc  = r_resp_pc;
    end
  end
`else
  assign w_push      = w_accept;
  assign instr_valid = !w_empty;
  assign instr_out   = w_empty ? C_NOP : w_head.instr;
  assign instr_pc    = w_empty ? r_last_pc : w_head.pc;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (redirect),
    .din   (w_push_entry),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_unused_full = w_full;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                           |
// | Brief    : randomized scoreboard bench for fetch_unit              |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int cyc; } req_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; int cyc; } exp_t;

  req_t        pend[$];   // granted, not yet answered by memory
  exp_t        exp_q[$];  // words decode must still receive, in order
  int          vectors = 0;
  int          errors  = 0;
  int          cycle   = 0;
  int          epoch   = 0;
  logic [31:0] model_pc = RST_PC;
  logic [31:0] last_pc  = RST_PC;
  int          p_gnt = 100, p_rv = 100, p_rdy = 100, p_redir = 0;
  bit          expect_req = 1'b0;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},    {31'b0, imem_req}, 32'd0);
    check({tag, "_imem_addr"},   imem_addr, RST_PC);
    check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_instr_out"},   instr_out, NOP);
    check({tag, "_instr_pc"},    instr_pc, RST_PC);
  endtask

  // One clock of stimulus: memory model, random inputs, grant bookkeeping
  task automatic step();
    req_t r;
    bit   rv;
    @(posedge clk);
    #1;
    cycle++;
    redirect = force_redir || ($urandom_range(0, 99) < p_redir);
    if (force_redir)                      redirect_pc = force_pc;
    else if ($urandom_range(0, 3) == 0)   redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
    else                                  redirect_pc = $urandom;
    force_redir = 1'b0;
    dec_ready = ($urandom_range(0, 99) < p_rdy);
    imem_gnt  = ($urandom_range(0, 99) < p_gnt);
    rv = 1'b0;
    imem_rdata = $urandom;
    if (pend.size() > 0 && pend[0].cyc < cycle && ($urandom_range(0, 99) < p_rv)) begin
      rv = 1'b1;
      r = pend.pop_front();
      imem_rdata = mem_word(r.addr);
      if (r.epoch == epoch && !redirect)
        exp_q.push_back('{data: mem_word(r.addr), pc: r.addr, cyc: cycle});
    end
    imem_rvalid = rv;
    #1;
    if (redirect) check("req_during_redirect", {31'b0, imem_req}, 32'd0);
    else if (expect_req) check("req_streaming", {31'b0, imem_req}, 32'd1);
    if (imem_req && imem_gnt) begin
      check("imem_addr", imem_addr, model_pc);
      pend.push_back('{addr: model_pc, epoch: epoch, cyc: cycle});
      model_pc = model_pc + 32'd4;
    end
    if (redirect) begin
      epoch++;
      model_pc = redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  // Monitor: compares the presented instruction against the scoreboard head
  initial begin : monitor
    int  lim;
    bit  exp_valid;
    forever begin
      @(negedge clk);
`ifdef FETCH_BYPASS_EN
      lim = cycle;
`else
      lim = cycle - 1;
`endif
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc <= lim);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
      if (instr_valid && exp_valid) begin
        check("instr_pc", instr_pc, exp_q[0].pc);
        check("instr_out", instr_out, exp_q[0].data);
        last_pc = exp_q[0].pc;
        if (dec_ready) void'(exp_q.pop_front());
      end else if (!instr_valid) begin
        check("idle_instr_out", instr_out, NOP);
        check("idle_instr_pc", instr_pc, last_pc);
      end
      if (redirect) exp_q.delete();
      check("credit_bound", {31'b0, (exp_q.size() + pend.size()) <= DEPTH}, 32'd1);
    end
  end

  task automatic set_mode(input int g, input int v, input int d, input int r);
    p_gnt = g; p_rv = v; p_rdy = d; p_redir = r;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : driver
    #2 rst = 1'b0;
    #1 check_reset_outputs("por");
    release_reset();

    // Streaming with a 1-cycle memory: requests every cycle, no bubbles
    set_mode(100, 100, 100, 0);
    expect_req = 1'b1;
    repeat (30) step();
    expect_req = 1'b0;

    // Decode stall fills the credit pool, then drains in order
    set_mode(100, 100, 0, 0);
    repeat (10) step();
    check("stall_req_low", {31'b0, imem_req}, 32'd0);
    check("stall_fill", exp_q.size() + pend.size(), DEPTH);
    set_mode(100, 100, 100, 0);
    repeat (10) step();

    // Redirect with responses in flight, then a wrapping redirect
    set_mode(100, 0, 100, 0);
    repeat (3) step();
    force_redir = 1'b1; force_pc = 32'h0000_0200;
    step();
    set_mode(100, 100, 100, 0);
    repeat (15) step();
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFE;
    step();
    repeat (10) step();

    // Randomized traffic with changing pressure
    for (int blk = 0; blk < 16; blk++) begin
      set_mode($urandom_range(30, 100), $urandom_range(20, 100),
               $urandom_range(10, 100), $urandom_range(0, 8));
      repeat (100) step();
    end

    // Reset with several requests in flight
    set_mode(100, 100, 100, 0);
    repeat (20) step();
    set_mode(100, 0, 100, 0);
    repeat (4) step();
    check("in_flight_before_reset", {31'b0, pend.size() >= 3}, 32'd1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("mid");
    pend.delete(); exp_q.delete();
    epoch++; model_pc = RST_PC; last_pc = RST_PC;
    imem_rvalid = 1'b0; imem_gnt = 1'b0; redirect = 1'b0;
    release_reset();
    set_mode(100, 100, 100, 0);
    expect_req = 1'b1;
    repeat (20) step();
    expect_req = 1'b0;

    set_mode(80, 70, 70, 4);
    repeat (300) step();

    // Drain everything still owed to decode
    set_mode(0, 100, 100, 0);
    for (int i = 0; i < 300 && (pend.size() + exp_q.size()) > 0; i++) step();
    step();
    check("drained", pend.size() + exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
